// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_if
// Brief    : Request/response handshake bundle for the multiply/divide unit.
// Revision : 1.0
// ============================================================================
interface muldiv_if #(
    parameter int XLEN = 32,
    parameter int OP_W = 3
);
    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] op;
    logic [XLEN-1:0] operand_1;
    logic [XLEN-1:0] operand_2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, operand_1, operand_2, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, operand_1, operand_2, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative RISC-V M-extension unit (shift-add mul, restoring div).
// Revision : 1.0
// ============================================================================
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int OP_W = 3
) (
    input  wire     clk,
    input  wire     rst_n,
    input  wire     flush,
    muldiv_if.slave bus
);
    localparam int            c_cnt_w    = $clog2(XLEN);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(XLEN - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [XLEN-1:0]    c_min      = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_calc = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nx;
    logic [OP_W-1:0]    r_op;
    logic [c_cnt_w-1:0] r_cnt;
    logic [XLEN:0]      r_a;
    logic [XLEN:0]      r_acc;
    logic [XLEN-1:0]    r_lo;
    logic               r_b_sgn;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [XLEN-1:0]    r_result;

    logic               w_accept;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_busy;
    logic               w_div_sgn;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic               w_fast;
    logic [XLEN-1:0]    w_fast_res;
    logic               w_op1_neg;
    logic               w_op2_neg;
    logic [XLEN-1:0]    w_abs1;
    logic [XLEN-1:0]    w_abs2;
    logic               w_sub;
    logic [XLEN+1:0]    w_psum;
    logic [XLEN:0]      w_shl;
    logic [XLEN:0]      w_trial;
    logic [XLEN:0]      w_acc_nx;
    logic [XLEN-1:0]    w_lo_nx;
    logic [XLEN-1:0]    w_quo;
    logic [XLEN-1:0]    w_rem;
    logic [XLEN-1:0]    w_calc_res;

    // Request decode and the no-iteration cases, evaluated on the live inputs.
    always_comb begin
        w_accept   = bus.in_valid && (r_state == c_idle) && !flush;
        w_div_sgn  = bus.op[2] && !bus.op[0];
        w_div_zero = bus.op[2] && (bus.operand_2 == '0);
        w_div_ovf  = w_div_sgn && (bus.operand_1 == c_min) && (bus.operand_2 == '1);
        w_fast     = w_div_zero || w_div_ovf;
        if (w_div_zero) begin
            w_fast_res = bus.op[1] ? bus.operand_1 : '1;
        end else begin
            w_fast_res = bus.op[1] ? '0 : bus.operand_1;
        end
        w_op1_neg = w_div_sgn && bus.operand_1[XLEN-1];
        w_op2_neg = w_div_sgn && bus.operand_2[XLEN-1];
        w_abs1    = w_op1_neg ? -bus.operand_1 : bus.operand_1;
        w_abs2    = w_op2_neg ? -bus.operand_2 : bus.operand_2;
    end

    // One iteration step; the result is formed from the step's outputs so the
    // last iteration edge also delivers the sign-corrected answer.
    always_comb begin
        w_sub   = r_b_sgn && (r_cnt == c_cnt_last);
        w_psum  = {r_acc[XLEN], r_acc};
        if (r_lo[0]) begin
            w_psum = w_sub ? ({r_acc[XLEN], r_acc} - {r_a[XLEN], r_a})
                           : ({r_acc[XLEN], r_acc} + {r_a[XLEN], r_a});
        end
        w_shl   = {r_acc[XLEN-1:0], r_lo[XLEN-1]};
        w_trial = w_shl - r_a;
        if (r_op[2]) begin
            w_acc_nx = w_trial[XLEN] ? w_shl : w_trial;
            w_lo_nx  = {r_lo[XLEN-2:0], !w_trial[XLEN]};
        end else begin
            w_acc_nx = w_psum[XLEN+1:1];
            w_lo_nx  = {w_psum[0], r_lo[XLEN-1:1]};
        end
        w_quo = r_neg_q ? -w_lo_nx : w_lo_nx;
        w_rem = r_neg_r ? -w_acc_nx[XLEN-1:0] : w_acc_nx[XLEN-1:0];
        if (r_op[2]) begin
            w_calc_res = r_op[1] ? w_rem : w_quo;
        end else begin
            w_calc_res = (r_op[1:0] == 2'b00) ? w_lo_nx : w_acc_nx[XLEN-1:0];
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_in_ready  = (r_state == c_idle);
        w_out_valid = (r_state == c_done);
        w_busy      = (r_state != c_idle);
        case (r_state)
            c_idle:  if (w_accept) w_state_nx = w_fast ? c_done : c_calc;
            c_calc:  if (r_cnt == c_cnt_last) w_state_nx = c_done;
            c_done:  if (bus.out_ready) w_state_nx = c_idle;
            default: w_state_nx = c_idle;
        endcase
        if (flush) begin
            w_state_nx = c_idle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_cnt    <= '0;
            r_a      <= '0;
            r_acc    <= '0;
            r_lo     <= '0;
            r_b_sgn  <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op    <= bus.op;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_b_sgn <= !bus.op[2] && (bus.op[1:0] == 2'b01);
            r_neg_q <= w_op1_neg ^ w_op2_neg;
            r_neg_r <= w_op1_neg;
            if (bus.op[2]) begin
                r_a  <= {1'b0, w_abs2};
                r_lo <= w_abs1;
            end else begin
                // MULH and MULHSU treat the multiplicand as signed.
                r_a  <= {(bus.op[1] ^ bus.op[0]) & bus.operand_1[XLEN-1], bus.operand_1};
                r_lo <= bus.operand_2;
            end
            if (w_fast) begin
                r_result <= w_fast_res;
            end
        end else if ((r_state == c_calc) && !flush) begin
            r_acc <= w_acc_nx;
            r_lo  <= w_lo_nx;
            r_cnt <= r_cnt + c_cnt_one;
            if (r_cnt == c_cnt_last) begin
                r_result <= w_calc_res;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.result    = r_result;

endmodule
`default_nettype wire
